// File: rtl/mips_mem_arbiter.sv
// Two-requester arbiter for the multicycle MIPS unified memory: core vs. loader,
// one access in flight, round-robin on contention, watchdog-terminated hung accesses.
module mips_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_done,
    input  logic              loader_req,
    input  logic              loader_we,
    input  logic [ADDR_W-1:0] loader_addr,
    input  logic [DATA_W-1:0] loader_wdata,
    output logic              loader_done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 2) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             grant;       // 1 = loader owns the current access
    logic             last_grant;  // winner of the most recent contended arbitration
    logic [CNT_W-1:0] cnt;
    logic             pick_loader;
    logic             timeout_hit;

    // Loader wins when alone, or when both ask and the core won the last contention.
    always_comb begin
        pick_loader = loader_req && (!core_req || !last_grant);
        timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_req || loader_req) begin
                        grant     <= pick_loader;
                        mem_we    <= pick_loader ? loader_we    : core_we;
                        mem_addr  <= pick_loader ? loader_addr  : core_addr;
                        mem_wdata <= pick_loader ? loader_wdata : core_wdata;
                        cnt       <= '0;
                        state     <= BUSY;
                        // Only contended grants move the round-robin pointer.
                        if (core_req && loader_req)
                            last_grant <= pick_loader;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        rdata <= mem_we ? '0 : mem_rdata;
                        err   <= 1'b0;
                        state <= DONE;
                    end else if (timeout_hit) begin
                        rdata <= '0;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register so reset kills them at once.
    always_comb begin
        mem_en      = (state == BUSY);
        core_done   = (state == DONE) && !grant;
        loader_done = (state == DONE) && grant;
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: single accesses, wait states, contention,
// watchdog timeout and its boundary, and asynchronous reset mid-access.
module tb_mips_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we, loader_req, loader_we;
    logic [AW-1:0] core_addr, loader_addr;
    logic [DW-1:0] core_wdata, loader_wdata;
    logic          core_done, loader_done, err, mem_en, mem_we, mem_ready;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_done(core_done),
        .loader_req(loader_req), .loader_we(loader_we), .loader_addr(loader_addr),
        .loader_wdata(loader_wdata), .loader_done(loader_done),
        .rdata(rdata), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if ({mem_en, mem_we, core_done, loader_done, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {mem_en, mem_we, core_done, loader_done, err});
        end
        n_chk++;
        if ({mem_addr, mem_wdata, rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h expected zeros", mem_addr, mem_wdata, rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: mem_en got %b expected 0", mem_en);
        end
    endtask

    task automatic test_core_read();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0040;
        @(negedge clk);
        n_chk++;
        if ({mem_en, mem_we, core_done} !== 3'b100 || mem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL core_rd_busy: en/we/done=%b addr=%h expected 100 addr=40", {mem_en, mem_we, core_done}, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'h8C08_0004;
        @(negedge clk);
        n_chk++;
        if ({mem_en, core_done, loader_done, err} !== 4'b0100 || rdata !== 32'h8C08_0004) begin
            n_fail++;
            $display("FAIL core_rd_done: en/cd/ld/err=%b rdata=%h expected 0100 rdata=8c080004", {mem_en, core_done, loader_done, err}, rdata);
        end
        core_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk);
        n_chk++;
        if ({mem_en, core_done} !== 2'b00 || rdata !== 32'h8C08_0004) begin
            n_fail++;
            $display("FAIL core_rd_after: en/done=%b rdata=%h expected 00 rdata=8c080004", {mem_en, core_done}, rdata);
        end
    endtask

    task automatic test_loader_write();
        loader_req = 1'b1; loader_we = 1'b1; loader_addr = 32'h100; loader_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++;
            if ({mem_en, mem_we, loader_done} !== 3'b110 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
                n_fail++;
                $display("FAIL ld_wr_busy%0d: en/we/done=%b addr=%h wdata=%h expected 110 100 deadbeef", i, {mem_en, mem_we, loader_done}, mem_addr, mem_wdata);
            end
            if (i == 3) mem_ready = 1'b1;
        end
        @(negedge clk);
        n_chk++;
        if ({mem_en, loader_done, core_done, err} !== 4'b0100 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL ld_wr_done: en/ld/cd/err=%b rdata=%h expected 0100 rdata=0", {mem_en, loader_done, core_done, err}, rdata);
        end
        loader_req = 1'b0; loader_we = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({mem_en, loader_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL ld_wr_after: en/done=%b expected 00", {mem_en, loader_done});
        end
    endtask

    // Expected winners: core (contended), loader (alone), then loader/core/loader/core contended.
    task automatic test_contention();
        logic [5:0] exp_core  = 6'b101001;  // bit i = 1 when core wins access i
        logic [5:0] nxt_core  = 6'b011110;  // core_req for the IDLE cycle after access i
        logic [5:0] nxt_load  = 6'b011111;
        logic       ec;
        core_we = 1'b0; loader_we = 1'b0;
        core_addr = 32'h200; loader_addr = 32'h300;
        core_req = 1'b1; loader_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ec = exp_core[i];
            @(negedge clk);
            n_chk++;
            if (mem_en !== 1'b1 || mem_addr !== (ec ? 32'h200 : 32'h300)) begin
                n_fail++;
                $display("FAIL cont_grant%0d: en=%b addr=%h expected 1 %h", i, mem_en, mem_addr, ec ? 32'h200 : 32'h300);
            end
            mem_ready = 1'b1; mem_rdata = 32'hA000_0000 + i;
            @(negedge clk);
            n_chk++;
            if ({core_done, loader_done} !== {ec, ~ec} || rdata !== 32'hA000_0000 + i) begin
                n_fail++;
                $display("FAIL cont_done%0d: cd/ld=%b rdata=%h expected %b%b %h", i, {core_done, loader_done}, rdata, ec, ~ec, 32'hA000_0000 + i);
            end
            mem_ready = 1'b0;
            if (ec) core_req = 1'b0; else loader_req = 1'b0;
            @(negedge clk);
            core_req = nxt_core[i]; loader_req = nxt_load[i];
        end
    endtask

    task automatic test_timeout();
        int n_en = 0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h500; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!mem_en) break;
            n_en++;
        end
        n_chk++;
        if (n_en !== TO) begin
            n_fail++;
            $display("FAIL to_en_cycles: got %0d expected %0d", n_en, TO);
        end
        n_chk++;
        if ({core_done, loader_done, err} !== 3'b101 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL to_done: cd/ld/err=%b rdata=%h expected 101 rdata=0", {core_done, loader_done, err}, rdata);
        end
        core_req = 1'b0;
        @(negedge clk);
        loader_req = 1'b1; loader_we = 1'b0; loader_addr = 32'h600;
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        n_chk++;
        if ({loader_done, err} !== 2'b10 || rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL to_recover: ld/err=%b rdata=%h expected 10 12345678", {loader_done, err}, rdata);
        end
        loader_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout_boundary();
        int n_en = 0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h700; mem_rdata = 32'h0BAD_F00D;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!mem_en) break;
            n_en++;
            if (n_en == TO) mem_ready = 1'b1;
        end
        n_chk++;
        if (n_en !== TO || {core_done, err} !== 2'b10 || rdata !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL to_boundary: en_cycles=%0d cd/err=%b rdata=%h expected %0d 10 0badf00d", n_en, {core_done, err}, rdata, TO);
        end
        core_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h800;
        @(negedge clk);
        n_chk++;
        if (mem_en !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_busy: mem_en got %b expected 1", mem_en);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({mem_en, core_done, loader_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL ar_immediate: en/cd/ld=%b expected 000", {mem_en, core_done, loader_done});
        end
        core_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_chk++;
            if ({mem_en, core_done, loader_done} !== 3'b000) begin
                n_fail++;
                $display("FAIL ar_no_done%0d: en/cd/ld=%b expected 000", i, {mem_en, core_done, loader_done});
            end
        end
        core_req = 1'b1; loader_req = 1'b1; core_addr = 32'h900; loader_addr = 32'hA00;
        @(negedge clk);
        n_chk++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h900) begin
            n_fail++;
            $display("FAIL ar_first_grant: en=%b addr=%h expected 1 900", mem_en, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        n_chk++;
        if ({core_done, loader_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL ar_first_done: cd/ld=%b expected 10", {core_done, loader_done});
        end
        core_req = 1'b0; loader_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        loader_req = 1'b0; loader_we = 1'b0; loader_addr = '0; loader_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        test_reset();
        test_core_read();
        test_loader_write();
        test_contention();
        test_timeout();
        test_timeout_boundary();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Sequences and shares the single unified memory of the multicycle MIPS core between two requesters.
- Requester 0 (core) is driven by the core's FSM controller for instruction fetch, load and store; requester 1 (loader) is the program-load/debug port.
- One access is in flight at a time against a variable-latency memory that signals completion with mem_ready.
- A timeout watchdog terminates hung accesses with an error response.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
TIMEOUT, 64, maximum BUSY cycles before forced error completion; 0 disables the watchdog

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
core_req  in  1  core access request; held until core_done
core_we  in  1  1=write, 0=read; stable while core_req
core_addr  in  ADDR_W  core address; stable while core_req
core_wdata  in  DATA_W  core write data; stable while core_req
core_done  out  1  one-cycle completion pulse to core
loader_req  in  1  loader access request; held until loader_done
loader_we  in  1  1=write, 0=read
loader_addr  in  ADDR_W  loader address
loader_wdata  in  DATA_W  loader write data
loader_done  out  1  one-cycle completion pulse to loader
rdata  out  DATA_W  read data, valid while either done is high
err  out  1  timeout flag, valid while either done is high
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, sampled only while mem_en=1

Behaviour:
- Clock and reset: all state is on clk; rst is asynchronous and active-high.
- Reset: state=IDLE; mem_en, mem_we, core_done, loader_done and err are 0; mem_addr, mem_wdata and rdata are 0; timeout counter is 0; last_grant=loader, so the core wins the first contention.
- All outputs are registered or decoded from state and registered fields only; no combinational path from any input to any output.

State machine, IDLE:
- With no requests, stay in IDLE.
- With any request, arbitrate, latch winner/we/addr/wdata into the mem_* registers, clear the counter and go to BUSY.
- Single request: that requester wins.
- Both requesting: round-robin; the requester not equal to last_grant wins, and last_grant is updated to the winner.

State machine, BUSY:
- mem_en=1; mem_we/mem_addr/mem_wdata stay stable for the whole state.
- mem_ready=1: capture rdata=mem_rdata on reads (rdata=0 on writes), err=0, go to DONE.
- Otherwise the counter increments.
- If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with mem_ready low: rdata=0, err=1, go to DONE.
- mem_ready takes priority over timeout in the same cycle.

State machine, DONE:
- mem_en=0, and the winner's done is high for exactly one cycle; then return to IDLE.
- Requests are ignored while in DONE.

Latency and handshake:
- Minimum latency with a zero-wait memory: req sampled in cycle N, mem_en in N+1, done in N+2, so 3 cycles per access including the IDLE cycle.
- Each access occupies the memory for exactly one mem_en burst.
- Requester rule: req must be low in the cycle after its done, or it issues a new access. rdata and err hold their values until the next DONE.
- The losing requester simply keeps req asserted; it is served next, with no starvation.
- mem_ready outside BUSY is ignored.
- req deasserted while not yet granted means the request is withdrawn and no access is issued.
- req deasserted after the grant has no effect: the access completes and done is still pulsed.

Reset mid-access:
- Asserting rst forces IDLE asynchronously, drops mem_en immediately and issues no done.
- The interrupted memory transaction is abandoned.

Test Plan:
- Core read, zero-wait: core_req with addr=0x0000_0040, memory returns 0x8C08_0004 on the first mem_en cycle -> mem_en for 1 cycle, core_done pulses 2 cycles after req, rdata=0x8C08_0004, err=0, loader_done stays 0.
- Loader write with 3 wait states: loader_we=1, addr=0x100, wdata=0xDEAD_BEEF, mem_ready on the 4th BUSY cycle -> mem_we=1 and mem_addr/mem_wdata stable for 4 cycles, loader_done on the following cycle.
- Contention: both requesting from reset -> core served first; loader served immediately after. Both requesting again -> loader first (round-robin alternation holds over 4 consecutive contended accesses).
- Timeout: TIMEOUT=8, mem_ready held low -> mem_en high for exactly 8 cycles, then the winner's done with err=1 and rdata=0; the next access completes normally with err=0.
- Ready at the timeout boundary: mem_ready=1 on the 8th BUSY cycle -> err=0, data captured.
- Async reset in BUSY: rst asserted mid-access between clock edges -> mem_en=0 before the next edge, no done pulse, and the first post-reset contention goes to the core.
